// File: rtl/mem_dma_master.sv
// Word-copy DMA initiator on the native valid/ready memory bus.
// Reads one word, writes it, and repeats until the programmed count is exhausted.
//
// state  | meaning
// IDLE   | waiting for start; result flags and checksum held
// RD     | read request at the source pointer, held until mem_ready
// RD_GAP | one idle bus cycle between the read and the write
// WR     | write request of the buffered word at the destination pointer
// WR_GAP | one idle bus cycle; loop to RD or finish
// FIN    | one-cycle done pulse
module mem_dma_master #(
  parameter int LEN_WIDTH   = 16,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          checksum,
  output logic                 mem_valid,
  output logic                 mem_instr,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    WR_GAP = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [31:0]          buffer;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 err_q;

  logic misaligned;
  logic len_zero;
  logic accept;
  logic rd_done;
  logic wr_done;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign len_zero   = (len_words == '0);
  assign accept     = (state == IDLE) && start;
  assign rd_done    = (state == RD) && mem_ready;
  assign wr_done    = (state == WR) && mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned || len_zero) state_nxt = FIN;
          else                        state_nxt = RD;
        end
      end
      RD:      if (mem_ready) state_nxt = RD_GAP;
      RD_GAP:  state_nxt = WR;
      WR:      if (mem_ready) state_nxt = WR_GAP;
      WR_GAP:  state_nxt = (remaining != '0) ? RD : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers and count only load on a transfer that will actually run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_ptr   <= 32'h0;
      dst_ptr   <= 32'h0;
      remaining <= '0;
      buffer    <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= misaligned;
        if (!misaligned && !len_zero) begin
          src_ptr   <= src_addr;
          dst_ptr   <= dst_addr;
          remaining <= len_words;
        end
      end
      if (rd_done) begin
        buffer <= mem_rdata;
      end
      if (wr_done) begin
        src_ptr   <= src_ptr + 32'd4;
        dst_ptr   <= dst_ptr + 32'd4;
        remaining <= remaining - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  generate
    if (CHECKSUM_EN) begin : g_checksum
      logic [31:0] sum_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          sum_q <= 32'h0;
        end else if (accept) begin
          sum_q <= 32'h0;
        end else if (rd_done) begin
          sum_q <= sum_q + mem_rdata;
        end
      end
      assign checksum = sum_q;
    end else begin : g_no_checksum
      assign checksum = 32'h0;
    end
  endgenerate

  assign busy      = (state == RD) || (state == RD_GAP) || (state == WR) || (state == WR_GAP);
  assign done      = (state == FIN);
  assign err       = err_q;
  assign mem_valid = (state == RD) || (state == WR);
  assign mem_instr = 1'b0;
  assign mem_addr  = (state == WR) ? dst_ptr : src_ptr;
  assign mem_wdata = buffer;
  assign mem_wstrb = (state == WR) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mem_dma_master.sv
// Bench for mem_dma_master: word-addressed memory responder with programmable
// ready latency and a forward-copy reference model of the expected memory image.
module tb_mem_dma_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len_words = 16'h0;
  logic        busy, done, err;
  logic [31:0] checksum;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  mem_dma_master #(.LEN_WIDTH(16), .CHECKSUM_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err), .checksum(checksum),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] mget(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] rget(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]]     = v;
    ref_mem[a[31:2]] = v;
  endtask

  task automatic fill(input logic [31:0] base, input int nwords);
    for (int i = 0; i < nwords; i++) poke(base + 32'(4 * i), $urandom);
  endtask

  // Responder: mem_ready on the k_ready-th consecutive valid cycle.
  int          k_ready = 2;
  int          vcnt = 0;
  int          req_count = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;
  logic [31:0] rd_addrs[$];

  always @(negedge clk) begin
    if (prev_ready) chk("valid_gap", {31'b0, mem_valid}, 32'h0);
    if (mem_valid) begin
      if (!prev_valid) begin
        req_count++;
        if (mem_wstrb == 4'h0) rd_addrs.push_back(mem_addr);
      end
      if (prev_valid && !prev_ready) begin
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_wstrb", {28'b0, mem_wstrb}, {28'b0, p_wstrb});
        if (mem_wstrb == 4'hF) chk("stall_wdata", mem_wdata, p_wdata);
      end
      vcnt++;
      if (vcnt >= k_ready) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'hF) mem[mem_addr[31:2]] = mem_wdata;
        else                   mem_rdata = mget(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      vcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    prev_valid = mem_valid;
    prev_ready = mem_ready && mem_valid;
    p_addr     = mem_addr;
    p_wdata    = mem_wdata;
    p_wstrb    = mem_wstrb;
  end

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int k, input bit inject);
    bit          bad;
    logic [31:0] sum;
    logic [31:0] v;
    int          exp_cyc;
    int          cyc;
    int          req0;
    bad = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    k_ready = k;
    sum = 32'h0;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        v = rget(s + 32'(4 * i));
        sum += v;
        ref_mem[(d + 32'(4 * i)) >> 2] = v;
      end
    end
    exp_cyc = (bad || n == 0) ? 2 : n * (2 * k + 2) + 2;
    req0 = req_count;
    rd_addrs.delete();

    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len_words = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_first", {31'b0, busy}, {31'b0, !(bad || n == 0)});
    while (!done && cyc < 2000) begin
      if (inject && cyc == 3) begin
        src_addr = 32'h1; dst_addr = 32'h2000; len_words = 16'd5; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", {31'b0, done}, 32'h1);
    chk("cycles", 32'(cyc + 1), 32'(exp_cyc));
    chk("busy_at_done", {31'b0, busy}, 32'h0);
    chk("err", {31'b0, err}, {31'b0, bad});
    chk("checksum", checksum, sum);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'h0);
    chk("err_held", {31'b0, err}, {31'b0, bad});
    if (bad || n == 0) begin
      chk("no_traffic", 32'(req_count), 32'(req0));
    end else begin
      for (int i = 0; i <= n; i++)
        chk("dst_word", mget(d + 32'(4 * i)), rget(d + 32'(4 * i)));
      chk("req_count", 32'(req_count - req0), 32'(2 * n));
    end
  endtask

  initial begin
    logic [31:0] s, d;
    int          n, wrs;
    bit          cur, prev_wr;

    #2;
    chk("rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_instr", {31'b0, mem_instr}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic four-word copy
    poke(32'h100, 32'h11111111);
    poke(32'h104, 32'h22222222);
    poke(32'h108, 32'h33333333);
    poke(32'h10C, 32'h44444444);
    fill(32'h200, 5);
    run_xfer(32'h100, 32'h200, 4, 2, 1'b0);
    chk("t1_sum_const", checksum, 32'hAAAAAAAA);
    chk("t1_word3", mget(32'h20C), 32'h44444444);

    // Zero length, misaligned, then err clears
    run_xfer(32'h400, 32'h500, 0, 2, 1'b0);
    run_xfer(32'h102, 32'h200, 3, 2, 1'b0);
    fill(32'h600, 3);
    run_xfer(32'h100, 32'h600, 2, 2, 1'b0);

    // Slow responder: ready on 7th valid cycle
    fill(32'h700, 3);
    run_xfer(32'h100, 32'h700, 2, 7, 1'b0);

    // Address wrap
    poke(32'hFFFFFFFC, $urandom);
    poke(32'h00000000, $urandom);
    fill(32'h300, 3);
    run_xfer(32'hFFFFFFFC, 32'h300, 2, 2, 1'b0);
    chk("wrap_reads", 32'(rd_addrs.size()), 32'h2);
    if (rd_addrs.size() == 2) chk("wrap_addr", rd_addrs[1], 32'h0);

    // Start pulse while busy must be ignored
    fill(32'h800, 5);
    run_xfer(32'h100, 32'h800, 4, 2, 1'b1);

    // Randomized transfers, overlapping regions included
    for (int it = 0; it < 24; it++) begin
      fill(32'h1000, 40);
      s = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      d = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) s = s | 32'h1;
      if ($urandom_range(0, 7) == 0) d = d | 32'h2;
      run_xfer(s, d, n, $urandom_range(1, 4), 1'b0);
    end

    // Reset during the third write of an eight-word copy
    fill(32'h900, 8);
    fill(32'hA00, 8);
    for (int i = 0; i < 2; i++) ref_mem[(32'hA00 + 32'(4 * i)) >> 2] = rget(32'h900 + 32'(4 * i));
    k_ready = 2;
    @(posedge clk); #1;
    src_addr = 32'h900; dst_addr = 32'hA00; len_words = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wrs = 0;
    prev_wr = 1'b0;
    for (int c = 0; c < 500 && wrs < 3; c++) begin
      @(posedge clk); #1;
      cur = mem_valid && (mem_wstrb == 4'hF);
      if (cur && !prev_wr) wrs++;
      prev_wr = cur;
    end
    chk("third_wr_reached", 32'(wrs), 32'h3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_done", {31'b0, done}, 32'h0);
    chk("mid_rst_err", {31'b0, err}, 32'h0);
    chk("mid_rst_checksum", checksum, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'b0, mem_valid}, 32'h0);
      chk("post_rst_busy", {31'b0, busy}, 32'h0);
    end
    for (int i = 0; i < 8; i++)
      chk("rst_dst_word", mget(32'hA00 + 32'(4 * i)), rget(32'hA00 + 32'(4 * i)));

    // Still functional afterwards
    fill(32'hB00, 4);
    run_xfer(32'h900, 32'hB00, 3, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
